// File: rtl/serial_parity_framer_if.sv
// Upstream serial-bit and downstream frame-result handshake bundle for serial_parity_framer.
interface serial_parity_framer_if;
    logic       up_valid;
    logic       up_ready;
    logic       up_data;
    logic       up_last;
    logic       down_valid;
    logic       down_ready;
    logic       down_parity;
    logic [7:0] down_len;
    logic       down_ovf;

    modport master (
        output up_valid, up_data, up_last, down_ready,
        input  up_ready, down_valid, down_parity, down_len, down_ovf
    );

    modport slave (
        input  up_valid, up_data, up_last, down_ready,
        output up_ready, down_valid, down_parity, down_len, down_ovf
    );
endinterface

// File: rtl/serial_parity_framer.sv
// Accumulates XOR parity and saturating length of a serial bit frame, then holds the result.
// Optional macro SERIAL_PARITY_FRAMER_OVF_DROP_EN drops overflowed frames instead of reporting.
module serial_parity_framer #(
    parameter int unsigned MAX_LEN = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_parity_framer_if.slave bus
);
    localparam logic [7:0] MaxLen = 8'(MAX_LEN);

    typedef enum logic {StAccum = 1'b0, StHold = 1'b1} state_e;

    state_e     state_q, state_d;
    logic       parity_q, parity_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic       out_parity_q, out_parity_d;
    logic [7:0] out_len_q, out_len_d;
    logic       cnt_full;
    logic [7:0] cnt_inc;
    logic       ovf_next;

    assign cnt_full = (cnt_q == MaxLen);
    assign cnt_inc  = cnt_full ? cnt_q : cnt_q + 8'd1;
    assign ovf_next = ovf_q | cnt_full;

    // Handshake flags depend on the state register only.
    assign bus.up_ready    = (state_q == StAccum);
    assign bus.down_valid  = (state_q == StHold);
    assign bus.down_parity = out_parity_q;
    assign bus.down_len    = out_len_q;

`ifdef SERIAL_PARITY_FRAMER_OVF_DROP_EN
    assign bus.down_ovf = 1'b0;
`else
    logic out_ovf_q, out_ovf_d;
    assign bus.down_ovf = out_ovf_q;
`endif

    always_comb begin
        state_d      = state_q;
        parity_d     = parity_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        out_parity_d = out_parity_q;
        out_len_d    = out_len_q;
`ifndef SERIAL_PARITY_FRAMER_OVF_DROP_EN
        out_ovf_d    = out_ovf_q;
`endif
        unique case (state_q)
            StAccum: begin
                if (bus.up_valid) begin
                    if (bus.up_last) begin
                        parity_d = 1'b0;
                        cnt_d    = 8'd0;
                        ovf_d    = 1'b0;
`ifdef SERIAL_PARITY_FRAMER_OVF_DROP_EN
                        if (!ovf_next) begin
                            out_parity_d = parity_q ^ bus.up_data;
                            out_len_d    = cnt_inc;
                            state_d      = StHold;
                        end
`else
                        out_parity_d = parity_q ^ bus.up_data;
                        out_len_d    = cnt_inc;
                        out_ovf_d    = ovf_next;
                        state_d      = StHold;
`endif
                    end else begin
                        parity_d = parity_q ^ bus.up_data;
                        cnt_d    = cnt_inc;
                        ovf_d    = ovf_next;
                    end
                end
            end
            StHold: begin
                if (bus.down_ready) state_d = StAccum;
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StAccum;
            parity_q     <= 1'b0;
            cnt_q        <= 8'd0;
            ovf_q        <= 1'b0;
            out_parity_q <= 1'b0;
            out_len_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            parity_q     <= parity_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            out_parity_q <= out_parity_d;
            out_len_q    <= out_len_d;
        end
    end

`ifndef SERIAL_PARITY_FRAMER_OVF_DROP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_ovf_q <= 1'b0;
        else        out_ovf_q <= out_ovf_d;
    end
`endif
endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed and randomised-gap bench for serial_parity_framer with MAX_LEN=16.
module tb_serial_parity_framer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_parity_framer_if bus ();

    serial_parity_framer #(.MAX_LEN(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic d, input logic l);
        bus.up_valid = 1'b1;
        bus.up_data  = d;
        bus.up_last  = l;
        tick();
        bus.up_valid = 1'b0;
        bus.up_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.up_valid   = 1'b1;
        bus.up_data    = 1'b1;
        bus.up_last    = 1'b1;
        bus.down_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.up_ready !== 1'b1 || bus.down_valid !== 1'b0 || bus.down_parity !== 1'b0 ||
                bus.down_len !== 8'd0 || bus.down_ovf !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got rdy=%b vld=%b par=%b len=%0d ovf=%b want 1 0 0 0 0",
                         i, bus.up_ready, bus.down_valid, bus.down_parity, bus.down_len, bus.down_ovf);
            end
            tick();
        end
        bus.up_valid = 1'b0;
        bus.up_last  = 1'b0;
        rst_n        = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1101;  // sent LSB first: 1,0,1,1
        bus.down_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.up_ready !== 1'b1) begin
                failures++;
                $display("FAIL basic_up_ready bit %0d: got %b want 1", i, bus.up_ready);
            end
            drive_bit(bits[i], i == 3);
            if (i < 3) begin
                checks++;
                if (bus.down_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early_valid bit %0d: got %b want 0", i, bus.down_valid);
                end
            end
        end
        checks++;
        if (bus.down_valid !== 1'b1 || bus.up_ready !== 1'b0 || bus.down_parity !== 1'b1 ||
            bus.down_len !== 8'd4 || bus.down_ovf !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got vld=%b rdy=%b par=%b len=%0d ovf=%b want 1 0 1 4 0",
                     bus.down_valid, bus.up_ready, bus.down_parity, bus.down_len, bus.down_ovf);
        end
        tick();
        checks++;
        if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_return_accum: got vld=%b rdy=%b want 0 1", bus.down_valid, bus.up_ready);
        end
    endtask

    task automatic test_hold_stall();
        bus.down_ready = 1'b0;
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        // Upstream keeps offering a last bit; it must be back-pressured.
        bus.up_valid = 1'b1;
        bus.up_data  = 1'b1;
        bus.up_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.down_valid !== 1'b1 || bus.up_ready !== 1'b0 || bus.down_parity !== 1'b0 ||
                bus.down_len !== 8'd2 || bus.down_ovf !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle %0d: got vld=%b rdy=%b par=%b len=%0d ovf=%b want 1 0 0 2 0",
                         i, bus.down_valid, bus.up_ready, bus.down_parity, bus.down_len, bus.down_ovf);
            end
            tick();
        end
        bus.up_valid   = 1'b0;
        bus.up_last    = 1'b0;
        bus.down_ready = 1'b1;
        checks++;
        if (bus.down_valid !== 1'b1 || bus.down_len !== 8'd2) begin
            failures++;
            $display("FAIL stall_before_xfer: got vld=%b len=%0d want 1 2", bus.down_valid, bus.down_len);
        end
        tick();
        checks++;
        if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_after_xfer: got vld=%b rdy=%b want 0 1", bus.down_valid, bus.up_ready);
        end
    endtask

    task automatic test_single_and_idle();
        drive_bit(1'b1, 1'b1);
        checks++;
        if (bus.down_valid !== 1'b1 || bus.down_parity !== 1'b1 || bus.down_len !== 8'd1) begin
            failures++;
            $display("FAIL single_bit: got vld=%b par=%b len=%0d want 1 1 1",
                     bus.down_valid, bus.down_parity, bus.down_len);
        end
        tick();
        // up_last without up_valid must be ignored.
        bus.up_valid = 1'b0;
        bus.up_data  = 1'b1;
        bus.up_last  = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.down_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_last_ignored: got vld=%b want 0", bus.down_valid);
        end
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        checks++;
        if (bus.down_valid !== 1'b1 || bus.down_parity !== 1'b1 || bus.down_len !== 8'd2) begin
            failures++;
            $display("FAIL idle_then_frame: got vld=%b par=%b len=%0d want 1 1 2",
                     bus.down_valid, bus.down_parity, bus.down_len);
        end
        tick();
    endtask

    task automatic test_overflow();
        int          lens [3] = '{16, 17, 18};
        logic        exp_par;
        logic        exp_ovf;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < lens[k]; i++) drive_bit(1'b1, i == lens[k] - 1);
            exp_par = lens[k][0];
            exp_ovf = (lens[k] > 16);
`ifdef SERIAL_PARITY_FRAMER_OVF_DROP_EN
            if (exp_ovf) begin
                checks++;
                if (bus.down_valid !== 1'b0 || bus.down_ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_drop len %0d: got vld=%b ovf=%b want 0 0",
                             lens[k], bus.down_valid, bus.down_ovf);
                end
            end else
`endif
            begin
                checks++;
                if (bus.down_valid !== 1'b1 || bus.down_parity !== exp_par ||
                    bus.down_len !== 8'd16 || bus.down_ovf !== exp_ovf) begin
                    failures++;
                    $display("FAIL ovf_frame len %0d: got vld=%b par=%b len=%0d ovf=%b want 1 %b 16 %b",
                             lens[k], bus.down_valid, bus.down_parity, bus.down_len, bus.down_ovf,
                             exp_par, exp_ovf);
                end
                tick();
            end
        end
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        checks++;
        if (bus.down_valid !== 1'b1 || bus.down_parity !== 1'b1 || bus.down_len !== 8'd3 ||
            bus.down_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_next_frame: got vld=%b par=%b len=%0d ovf=%b want 1 1 3 0",
                     bus.down_valid, bus.down_parity, bus.down_len, bus.down_ovf);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.up_ready !== 1'b1 || bus.down_len !== 8'd0 || bus.down_parity !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async: got rdy=%b len=%0d par=%b want 1 0 0",
                     bus.up_ready, bus.down_len, bus.down_parity);
        end
        tick();
        rst_n = 1'b1;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b1);
        checks++;
        if (bus.down_valid !== 1'b1 || bus.down_parity !== 1'b1 || bus.down_len !== 8'd2 ||
            bus.down_ovf !== 1'b0) begin
            failures++;
            $display("FAIL midreset_frame: got vld=%b par=%b len=%0d ovf=%b want 1 1 2 0",
                     bus.down_valid, bus.down_parity, bus.down_len, bus.down_ovf);
        end
        tick();
        // Reset while a result is pending discards it.
        bus.down_ready = 1'b0;
        drive_bit(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.down_valid !== 1'b0 || bus.up_ready !== 1'b1) begin
            failures++;
            $display("FAIL holdreset_async: got vld=%b rdy=%b want 0 1", bus.down_valid, bus.up_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.down_valid !== 1'b0) begin
            failures++;
            $display("FAIL holdreset_no_result: got vld=%b want 0", bus.down_valid);
        end
        bus.down_ready = 1'b1;
    endtask

    task automatic test_random();
        int         len;
        int         wait_cnt;
        logic       exp_par;
        logic [7:0] exp_len;
        logic       exp_ovf;
        logic       b;
        bit         got;
        for (int f = 0; f < 1000; f++) begin
            len     = $urandom_range(1, 20);
            exp_par = 1'b0;
            exp_len = 8'd0;
            exp_ovf = 1'b0;
            for (int i = 0; i < len; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    bus.up_valid = 1'b0;
                    bus.up_data  = 1'($urandom);
                    bus.up_last  = 1'($urandom);
                    tick();
                end
                b = 1'($urandom);
                exp_par = exp_par ^ b;
                if (exp_len == 8'd16) exp_ovf = 1'b1;
                else                  exp_len = exp_len + 8'd1;
                drive_bit(b, i == len - 1);
            end
`ifdef SERIAL_PARITY_FRAMER_OVF_DROP_EN
            if (exp_ovf) begin
                checks++;
                if (bus.down_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_drop frame %0d: got vld=%b want 0", f, bus.down_valid);
                end
                continue;
            end
`endif
            got      = 1'b0;
            wait_cnt = 0;
            while (!got && wait_cnt < 50) begin
                bus.down_ready = 1'($urandom);
                if (bus.down_valid === 1'b1 && bus.down_ready) begin
                    got = 1'b1;
                    checks++;
                    if (bus.down_parity !== exp_par || bus.down_len !== exp_len ||
                        bus.down_ovf !== exp_ovf) begin
                        failures++;
                        $display("FAIL rand_result frame %0d: got par=%b len=%0d ovf=%b want %b %0d %b",
                                 f, bus.down_parity, bus.down_len, bus.down_ovf,
                                 exp_par, exp_len, exp_ovf);
                    end
                end
                tick();
                wait_cnt++;
            end
            checks++;
            if (!got || bus.down_valid !== 1'b0) begin
                failures++;
                $display("FAIL rand_handshake frame %0d: got seen=%b vld_after=%b want 1 0",
                         f, got, bus.down_valid);
            end
        end
        bus.down_ready = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_hold_stall();
        test_single_and_idle();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
